// File: rtl/datamem_pkg.sv
// Shared definitions for the pipelined data memory: default geometry, response record,
// configuration sanity check and the per-byte parity helper used when DATAMEM_PARITY_EN is defined.
package datamem_pkg;

    localparam int DM_DW        = 32;
    localparam int DM_AW        = 14;
    localparam int DM_DEPTH     = 1024;
    localparam int DM_RD_LAT    = 1;
    localparam int DM_OUT_DEPTH = 4;

    typedef struct packed {
        logic [DM_DW-1:0] rdata;
        logic             err;
        logic             perr;
    } dm_rsp_t;

    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

    // Outstanding limit must cover every pipeline stage plus at least one buffered response.
    function automatic bit cfg_ok(input int dw, input int aw, input int depth,
                                  input int rd_lat, input int out_depth);
        return (dw > 0) && (dw % 8 == 0) && (depth >= 2) && (depth <= (1 << aw)) &&
               ((rd_lat == 1) || (rd_lat == 2)) && (out_depth >= rd_lat + 1);
    endfunction

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/datamem_rsp_fifo.sv
// Circular response buffer for datamem_pipe; the caller guarantees it never overflows,
// so a push into a full buffer only ever happens together with a pop.
module datamem_rsp_fifo
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  T                           push_data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/datamem_pipe.sv
// Pipelined data memory with valid/ready channels, byte enables and out-of-range error reporting.
// Optional per-byte even parity storage and checking is enabled by defining DATAMEM_PARITY_EN.
module datamem_pipe
    import datamem_pkg::*;
#(
    parameter int DW        = DM_DW,
    parameter int AW        = DM_AW,
    parameter int DEPTH     = DM_DEPTH,
    parameter int RD_LAT    = DM_RD_LAT,
    parameter int OUT_DEPTH = DM_OUT_DEPTH
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DW/8-1:0]   req_be,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_perr
);

    localparam int            BYTES     = bytes_of(DW);
    localparam int            IW        = $clog2(DEPTH);
    localparam int            CW        = $clog2(OUT_DEPTH + 1);
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          perr;
    } rsp_rec_t;

    if (!cfg_ok(DW, AW, DEPTH, RD_LAT, OUT_DEPTH)) begin : g_bad_cfg
        $error("datamem_pipe: illegal parameter combination");
    end

    logic          accept;
    logic          rsp_hs;
    logic          in_range;
    logic          wr_en;
    logic [IW-1:0] idx;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] mem_q [DEPTH];

    logic          s0_valid_q;
    logic          s0_rd_q;
    logic          s0_err_q;
    logic [DW-1:0] s0_data_q;
    logic          par_mism;

    rsp_rec_t      rec0;
    rsp_rec_t      push_rec;
    logic          push;
    rsp_rec_t      head;
    rsp_rec_t      last_q;
    rsp_rec_t      out_rec;

    assign in_range  = {1'b0, req_addr} < DEPTH_LIM;
    assign idx       = req_addr[IW-1:0];
    assign rsp_valid = (fifo_count != '0);
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign req_ready = rst_n & ((count_q < CW'(OUT_DEPTH)) | rsp_hs);
    assign accept    = req_valid & req_ready;
    assign wr_en     = accept & req_we & in_range;

    // Array has no reset so its contents survive rst_n; only enabled bytes are written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s0_rd_q   <= ~req_we & in_range;
            s0_err_q  <= ~in_range;
            s0_data_q <= mem_q[idx];
        end
    end

`ifdef DATAMEM_PARITY_EN
    logic [BYTES-1:0] par_q [DEPTH];
    logic [BYTES-1:0] s0_par_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    par_q[idx][b] <= byte_parity(req_wdata[8*b +: 8]);
                end
            end
        end
        if (accept) begin
            s0_par_q <= par_q[idx];
        end
    end

    always_comb begin
        par_mism = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            par_mism = par_mism | (byte_parity(s0_data_q[8*b +: 8]) ^ s0_par_q[b]);
        end
    end
`else
    assign par_mism = 1'b0;
`endif

    // Writes and errors always answer with zero data; parity is only meaningful on good reads.
    always_comb begin
        rec0       = '0;
        rec0.err   = s0_err_q;
        if (s0_rd_q) begin
            rec0.rdata = s0_data_q;
            rec0.perr  = par_mism;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic     s1_valid_q;
        rsp_rec_t s1_rec_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= s0_valid_q;
            end
        end

        always_ff @(posedge clk) begin
            if (s0_valid_q) begin
                s1_rec_q <= rec0;
            end
        end

        assign push     = s1_valid_q;
        assign push_rec = s1_rec_q;
    end else begin : g_lat1
        assign push     = s0_valid_q;
        assign push_rec = rec0;
    end

    always_comb begin
        case ({accept, rsp_hs})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    datamem_rsp_fifo #(
        .DEPTH (OUT_DEPTH),
        .T     (rsp_rec_t)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_i       (rsp_hs),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Remember the last consumed response so the outputs hold steady while the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (rsp_hs) begin
            last_q <= head;
        end
    end

    assign out_rec   = rsp_valid ? head : last_q;
    assign rsp_rdata = out_rec.rdata;
    assign rsp_err   = out_rec.err;
    assign rsp_perr  = out_rec.perr;

endmodule

// File: tb/tb_datamem_pipe.sv
// Scoreboard bench for datamem_pipe: a word-array model predicts every response at acceptance,
// an independent monitor pops and compares on each response handshake.
module tb_datamem_pipe;
    import datamem_pkg::*;

    localparam int RD_LAT    = 1;
    localparam int OUT_DEPTH = 4;
    localparam int DEPTH     = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [13:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_perr;

    int          total = 0;
    int          bad = 0;
    dm_rsp_t     sb[$];
    logic [31:0] mm [0:DEPTH-1];
    logic [31:0] last_rdata = '0;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    datamem_pipe #(
        .DW        (32),
        .AW        (14),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_perr  (rsp_perr)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour: out of range -> error, read -> current word, write -> merge enabled bytes.
    task automatic modelAccept(input logic we, input logic [3:0] be, input logic [13:0] addr,
                               input logic [31:0] wd);
        dm_rsp_t e;
        e = '0;
        if (int'(addr) >= DEPTH) begin
            e.err = 1'b1;
        end else if (!we) begin
            e.rdata = mm[addr];
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mm[addr][8*b +: 8] = wd[8*b +: 8];
            end
        end
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [13:0] addr,
                                 input logic [31:0] wd, output bit acc);
        @(negedge clk);
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        #4;
        acc = req_ready;
        if (acc) modelAccept(we, be, addr, wd);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [3:0] be, input logic [13:0] addr,
                         input logic [31:0] wd);
        bit acc;
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 64) begin
            applyStimulus(we, be, addr, wd, acc);
            tries++;
        end
        if (!acc) checkOutput("req_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_left", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        dm_rsp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", {rsp_rdata, rsp_err, rsp_perr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp", {rsp_rdata, rsp_err, rsp_perr}, 64'(e));
                end
                last_rdata = rsp_rdata;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit          acc;
        int          acc_n;
        int          r;
        logic [13:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("rst_rsp_err",   64'(rsp_err),   64'd0);
        checkOutput("rst_rsp_perr",  64'(rsp_perr),  64'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 14'(i), $urandom);
        drain();

        issue(1'b1, 4'hF, 14'd5, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 14'd5, 32'h0);
        drain();
        checkOutput("t1_rd_data", 64'(last_rdata), 64'hDEADBEEF);
        checkOutput("t1_idle_valid", 64'(rsp_valid), 64'd0);
        checkOutput("t1_hold_rdata", 64'(rsp_rdata), 64'hDEADBEEF);

        issue(1'b1, 4'hF, 14'd7, 32'h11223344);
        issue(1'b1, 4'b0010, 14'd7, 32'hAABBCCDD);
        issue(1'b0, 4'h0, 14'd7, 32'h0);
        drain();
        checkOutput("t2_rd_data", 64'(last_rdata), 64'h1122CC44);

        issue(1'b0, 4'h0, 14'd3, 32'h0);
        for (int c = 0; c < RD_LAT; c++) begin
            @(negedge clk);
            #1 checkOutput("lat_early_valid", 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);
        #1 checkOutput("lat_valid", 64'(rsp_valid), 64'd1);
        drain();

        rsp_ready = 1'b0;
        acc_n = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            applyStimulus(1'b0, 4'h0, 14'(acc_n), 32'h0, acc);
            if (acc) acc_n++;
        end
        checkOutput("t3_accepts", 64'(acc_n), 64'(OUT_DEPTH));
        @(negedge clk);
        #1;
        checkOutput("t3_req_ready_full", 64'(req_ready), 64'd0);
        checkOutput("t3_rsp_valid_full", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        issue(1'b0, 4'h0, 14'd4, 32'h0);
        issue(1'b0, 4'h0, 14'd5, 32'h0);
        drain();

        issue(1'b1, 4'hF, 14'd1024, 32'hFFFFFFFF);
        issue(1'b0, 4'h0, 14'd1024, 32'h0);
        issue(1'b0, 4'h0, 14'd0, 32'h0);
        drain();
        checkOutput("t4_addr0", 64'(last_rdata), 64'(mm[0]));

        rsp_ready = 1'b0;
        issue(1'b0, 4'h0, 14'd1, 32'h0);
        issue(1'b0, 4'h0, 14'd2, 32'h0);
        issue(1'b0, 4'h0, 14'd3, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("t5_req_ready", 64'(req_ready), 64'd0);
        checkOutput("t5_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1 checkOutput("t5_no_stale", 64'(rsp_valid), 64'd0);
        issue(1'b0, 4'h0, 14'd5, 32'h0);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 16)       a = 14'(r);
            else if (r == 19) a = 14'h3FFF;
            else              a = 14'(1024 + r);
            issue(1'($urandom), 4'($urandom), a, $urandom);
        end
        rand_rdy = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
